// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//   Raster timing generator. A clock divider produces one pixel strobe every
//   PIX_DIV clocks; each strobe advances a (col,row) raster position over
//   H_TOTAL x V_TOTAL. Sync, active-video, linear address and frame-start
//   outputs are registered on the same edge as col/row, so they always
//   describe the position currently shown on col/row.
//
//   Optional feature: define VTG_FRAME_CNT_EN to add a 16-bit frame counter
//   output (frame_cnt) that advances with every frame_start.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   enable       in   run; low freezes all state
//   pixel_pulse  out  one-clk strobe per pixel period
//   col          out  horizontal position 0..H_TOTAL-1
//   row          out  vertical position 0..V_TOTAL-1
//   addr         out  linear address of the visible region (mod 2^ADDR_W)
//   hsync        out  horizontal sync, asserted level HS_POL
//   vsync        out  vertical sync, asserted level VS_POL
//   active       out  current (col,row) is visible
//   frame_start  out  one-clk strobe when (col,row) wraps to (0,0)
//   frame_cnt    out  frames started (only with VTG_FRAME_CNT_EN)
// ---------------------------------------------------------------------------
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIX_DIV  = 6,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int ADDR_W   = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              pixel_pulse,
    output logic [9:0]        col,
    output logic [9:0]        row,
    output logic [ADDR_W-1:0] addr,
    output logic              hsync,
    output logic              vsync,
    output logic              active,
    output logic              frame_start
`ifdef VTG_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(PIX_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q;
    logic [9:0]       col_nxt;
    logic [9:0]       row_nxt;
    logic             frame_wrap;

    // The strobe is decoded from the divider so it lines up with the edge
    // that advances col/row; gating with enable keeps it quiet while frozen.
    assign pixel_pulse = enable && (div_q == DIV_LAST);

    // Next raster position, consumed only on a pixel_pulse edge. The
    // registered outputs below are decoded from this next position so they
    // land on the same edge as col/row.
    // NOTE: every signal driven here gets a default first, otherwise the
    // incomplete if/else would infer a latch.
    always_comb begin
        col_nxt    = col + 10'd1;
        row_nxt    = row;
        frame_wrap = 1'b0;
        if (col == H_LAST) begin
            col_nxt = '0;
            if (row == V_LAST) begin
                row_nxt    = '0;
                frame_wrap = 1'b1;
            end else begin
                row_nxt = row + 10'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            col         <= '0;
            row         <= '0;
            addr        <= '0;
            active      <= 1'b1;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            frame_start <= 1'b0;
        end else begin
            // frame_start is a single-clock strobe: cleared on every edge
            // unless this edge performs the wrap.
            frame_start <= 1'b0;
            if (enable) begin
                if (pixel_pulse) begin
                    div_q       <= '0;
                    col         <= col_nxt;
                    row         <= row_nxt;
                    active      <= (col_nxt < H_ACT) && (row_nxt < V_ACT);
                    hsync       <= (col_nxt >= HS_START && col_nxt < HS_END) ? HS_POL : ~HS_POL;
                    vsync       <= (row_nxt >= VS_START && row_nxt < VS_END) ? VS_POL : ~VS_POL;
                    frame_start <= frame_wrap;
                    // addr counts visible pixels already left behind, so it
                    // advances when leaving an active position.
                    if (frame_wrap) begin
                        addr <= '0;
                    end else if (active) begin
                        addr <= addr + ADDR_W'(1);
                    end
                end else begin
                    div_q <= div_q + DIV_W'(1);
                end
            end
        end
    end

`ifdef VTG_FRAME_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (pixel_pulse && frame_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//   Drives a small raster configuration with randomized enable and occasional
//   asynchronous resets. The reference model only tracks the number of
//   enabled clocks since reset and derives every output from it arithmetically
//   (pixel index, raster position, visible pixels passed, frame count).
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 2;
    localparam int VA  = 5;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int PD  = 3;
    localparam int AW  = 5;
    localparam bit HSP = 1'b0;
    localparam bit VSP = 1'b1;

    localparam int HT    = HA + HFP + HS + HBP;
    localparam int VT    = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          pixel_pulse;
    logic [9:0]    col;
    logic [9:0]    row;
    logic [AW-1:0] addr;
    logic          hsync;
    logic          vsync;
    logic          active;
    logic          frame_start;
`ifdef VTG_FRAME_CNT_EN
    logic [15:0]   frame_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Model state: enabled clocks since reset, and frame_start expectation.
    int e    = 0;
    bit fs_m = 1'b0;

    video_timing_gen #(
        .H_ACTIVE (HA),  .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA),  .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .PIX_DIV  (PD),  .HS_POL (HSP), .VS_POL (VSP), .ADDR_W (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pixel_pulse (pixel_pulse),
        .col         (col),
        .row         (row),
        .addr        (addr),
        .hsync       (hsync),
        .vsync       (vsync),
        .active      (active),
        .frame_start (frame_start)
`ifdef VTG_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        int p, dv, pos, c, r, a;
        p   = e / PD;
        dv  = e % PD;
        pos = p % FRAME;
        c   = pos % HT;
        r   = pos / HT;
        // Visible pixels strictly before (c,r) in raster order.
        if (r < VA) a = r * HA + ((c < HA) ? c : HA);
        else        a = VA * HA;
        a = a % (1 << AW);
        check("col", 64'(col), 64'(c));
        check("row", 64'(row), 64'(r));
        check("pixel_pulse", 64'(pixel_pulse), 64'(enable && !rst && dv == PD - 1));
        check("active", 64'(active), 64'(c < HA && r < VA));
        check("hsync", 64'(hsync), 64'((c >= HA + HFP && c < HA + HFP + HS) ? HSP : !HSP));
        check("vsync", 64'(vsync), 64'((r >= VA + VFP && r < VA + VFP + VS) ? VSP : !VSP));
        check("addr", 64'(addr), 64'(a));
        check("frame_start", 64'(frame_start), 64'(fs_m));
`ifdef VTG_FRAME_CNT_EN
        check("frame_cnt", 64'(frame_cnt), 64'((p / FRAME) % 65536));
`endif
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst = 1'b0;
            if (cyc < 500)       enable = 1'b1;   // clean run through a full frame
            else if (cyc < 520)  enable = 1'b0;   // long freeze mid-frame
            else                 enable = ($urandom_range(0, 99) < 85);

            if (cyc == 1200 || (cyc > 600 && $urandom_range(0, 999) == 0)) begin
                // Asynchronous reset: outputs must change before any edge.
                rst = 1'b1;
                #1;
                e    = 0;
                fs_m = 1'b0;
                check_all();
            end

            @(posedge clk);
            if (!rst) begin
                if (enable) begin
                    e++;
                    fs_m = (e % PD == 0) && ((e / PD) % FRAME == 0);
                end else begin
                    fs_m = 1'b0;
                end
            end
            #1;
            check_all();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch/sync widths in pixels; H_TOTAL = sum of the four H values.
REQ-003 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, in lines; V_TOTAL = sum of the four V values.
REQ-004 SHALL have parameter PIX_DIV, default 6, clk cycles per pixel (>=2).
REQ-005 SHALL have parameters HS_POL/VS_POL, default 0, sync asserted level; ADDR_W, default 20, address width.
REQ-006 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port enable  input  1  run; low freezes all state.
REQ-009 SHALL have port pixel_pulse  output  1  one-clk strobe per pixel period.
REQ-010 SHALL have port col  output  10  horizontal counter 0..H_TOTAL-1.
REQ-011 SHALL have port row  output  10  vertical counter 0..V_TOTAL-1.
REQ-012 SHALL have port addr  output  ADDR_W  linear pixel address of visible region.
REQ-013 SHALL have ports hsync, vsync  output  1 each  sync outputs.
REQ-014 SHALL have port active  output  1  current (col,row) is visible.
REQ-015 SHALL have port frame_start  output  1  one-clk strobe on wrap to (0,0).

Function
REQ-016 Divider SHALL count 0..PIX_DIV-1 while enable=1; pixel_pulse=1 exactly in the cycle the divider equals PIX_DIV-1.
REQ-017 On a clk edge where pixel_pulse=1: col increments; at H_TOTAL-1 col wraps to 0 and row increments; at row V_TOTAL-1 row also wraps to 0.
REQ-018 active, hsync, vsync, addr, frame_start SHALL be registered, updating on the same edge as col/row and consistent with the new col/row (zero skew).
REQ-019 active=1 iff col<H_ACTIVE and row<V_ACTIVE.
REQ-020 hsync=HS_POL iff H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL; vsync likewise with V values and VS_POL, independent of col.
REQ-021 addr SHALL equal the count of active pixels since frame start: increments by 1 on the edge that leaves an active position; returns to 0 on the wrap to (0,0); held outside active region.
REQ-022 frame_start SHALL be 1 for one clk on the edge where (col,row) becomes (0,0) by wrap; not asserted on exit from reset.
REQ-023 enable=0 SHALL hold divider, counters, addr and sync outputs; pixel_pulse and frame_start 0; resuming continues from held values.
REQ-024 Counter widths SHALL accommodate H_TOTAL, V_TOTAL <= 1024; addr wraps modulo 2^ADDR_W.

Reset
REQ-025 On rst=1, asynchronously: divider=0, col=0, row=0, addr=0, active=1, hsync=~HS_POL, vsync=~VS_POL, pixel_pulse=0, frame_start=0.
REQ-026 rst asserted mid-frame SHALL abort immediately; first pixel_pulse after release occurs PIX_DIV enabled clks later.

Configuration
REQ-027 Macro VTG_FRAME_CNT_EN defined: extra output frame_cnt (16 bits) increments with each frame_start, wraps at 65535->0, reset 0, held when enable=0.
REQ-028 Macro undefined: frame_cnt port and logic absent; all other behaviour identical.

Verification
REQ-029 Reset then enable=1, defaults -> pixel_pulse every 6th clk; first at clk 6; col=1 after it.
REQ-030 Run one line -> hsync low for exactly 96 pixel periods, col 656..751; active low for col 640..799; row=1 after col 799->0.
REQ-031 Run full frame (800x525 pixels) -> frame_start single pulse at wrap; addr reaches 307199 at last active pixel and reads 0 at (0,0); vsync low rows 490..491 only.
REQ-032 Drop enable for 20 clks mid-line at col=100 -> col, addr, divider unchanged, no pulses; resume continues at col 101 after remaining divider cycles.
REQ-033 Assert rst at row 300/col 400 -> all outputs at reset values same cycle, no frame_start on release.
REQ-034 With VTG_FRAME_CNT_EN, H_ACTIVE=4, totals 8x4, PIX_DIV=2 -> frame_cnt=3 after 3 frames (192 clks).
